// File: rtl/varwidth_fifo_if.sv
// varwidth_fifo_if: write/read bus for varwidth_fifo; wr_pad and PAD_WIDTH exist only when VARFIFO_PAD_EN is defined.
interface varwidth_fifo_if #(
    parameter int DIN_WIDTH  = 10,
    parameter int DOUT_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
`ifdef VARFIFO_PAD_EN
    ,
    parameter int PAD_WIDTH  = 2
`endif
);
    logic                  wr_en;
    logic [DIN_WIDTH-1:0]  wr_data;
`ifdef VARFIFO_PAD_EN
    logic [PAD_WIDTH-1:0]  wr_pad;
`endif
    logic                  flush;
    logic                  rd_en;
    logic [DOUT_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  overflow;
    logic                  underflow;

    modport slave (
`ifdef VARFIFO_PAD_EN
        input  wr_pad,
`endif
        input  wr_en, wr_data, flush, rd_en,
        output rd_data, rd_valid, full, empty, word_count, overflow, underflow
    );

    modport master (
`ifdef VARFIFO_PAD_EN
        output wr_pad,
`endif
        output wr_en, wr_data, flush, rd_en,
        input  rd_data, rd_valid, full, empty, word_count, overflow, underflow
    );
endinterface

// File: rtl/varwidth_fifo.sv
// varwidth_fifo: packs DIN_WIDTH samples into WORD_WIDTH words, unpacks them as DOUT_WIDTH slices.
// Define VARFIFO_PAD_EN to store wr_pad in the top PAD_WIDTH bits of each committed word.
module varwidth_fifo #(
    parameter int DIN_WIDTH  = 10,
    parameter int DOUT_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PAD_WIDTH  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    varwidth_fifo_if.slave  bus
);
`ifdef VARFIFO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int PAD_EFF     = PAD_EN ? PAD_WIDTH : 0;
    localparam int WR_PER_WORD = (WORD_WIDTH - PAD_EFF) / DIN_WIDTH;
    localparam int RD_PER_WORD = WORD_WIDTH / DOUT_WIDTH;
    localparam int WS_W        = $clog2(WR_PER_WORD > 1 ? WR_PER_WORD : 2);
    localparam int RS_W        = $clog2(RD_PER_WORD > 1 ? RD_PER_WORD : 2);

    typedef logic [WORD_WIDTH-1:0] word_t;

    word_t                 r_mem [DEPTH];
    word_t                 r_stage;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [WS_W-1:0]       r_wr_ws;
    logic [RS_W-1:0]       r_rd_ws;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DOUT_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_over;
    logic                  r_under;

    word_t                 w_stage_nx;
    word_t                 w_word;
    logic [DOUT_WIDTH-1:0] w_slice;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_last;
    logic                  w_flush_req;
    logic                  w_commit;
    logic                  w_rd_acc;
    logic                  w_pop;

    always_comb begin
        w_full      = r_count == (ADDR_WIDTH + 1)'(DEPTH);
        w_empty     = r_count == '0;
        w_wr_acc    = bus.wr_en && !w_full;
        w_last      = w_wr_acc && r_wr_ws == WS_W'(WR_PER_WORD - 1);
        w_flush_req = bus.flush && r_wr_ws != '0;
        w_commit    = w_last || (w_flush_req && !w_full);
        // slots are written once per word and staging clears on commit, so OR-in is enough
        w_stage_nx  = w_wr_acc ? r_stage | (word_t'(bus.wr_data) << (DIN_WIDTH * r_wr_ws)) : r_stage;
`ifdef VARFIFO_PAD_EN
        w_word      = w_stage_nx | (word_t'(bus.wr_pad) << (WORD_WIDTH - PAD_WIDTH));
`else
        w_word      = w_stage_nx;
`endif
        w_rd_acc    = bus.rd_en && !w_empty;
        w_pop       = w_rd_acc && r_rd_ws == RS_W'(RD_PER_WORD - 1);
        w_slice     = DOUT_WIDTH'(r_mem[r_rd_ptr] >> (DOUT_WIDTH * r_rd_ws));
    end

    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ws    <= '0;
            r_rd_ws    <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_over     <= 1'b0;
            r_under    <= 1'b0;
        end else begin
            r_stage    <= w_commit ? '0 : w_stage_nx;
            r_wr_ws    <= w_commit ? '0 : r_wr_ws + WS_W'(w_wr_acc);
            r_wr_ptr   <= r_wr_ptr + ADDR_WIDTH'(w_commit);
            r_rd_ws    <= w_pop ? '0 : r_rd_ws + RS_W'(w_rd_acc);
            r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(w_pop);
            r_count    <= r_count + (ADDR_WIDTH + 1)'(w_commit) - (ADDR_WIDTH + 1)'(w_pop);
            r_rd_valid <= w_rd_acc;
            r_rd_data  <= w_rd_acc ? w_slice : r_rd_data;
            r_over     <= r_over | (w_full && (bus.wr_en || w_flush_req));
            r_under    <= r_under | (bus.rd_en && w_empty);
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.word_count = r_count;
    assign bus.overflow   = r_over;
    assign bus.underflow  = r_under;
endmodule

// File: doc/varwidth_fifo.md
VARWIDTH_FIFO -- requirements
Module: varwidth_fifo

Interface
REQ-001 Parameter DIN_WIDTH, default 10: write sample width in bits.
REQ-002 Parameter DOUT_WIDTH, default 8: read slice width in bits; SHALL divide WORD_WIDTH.
REQ-003 Parameter WORD_WIDTH, default 32: memory word width.
REQ-004 Parameter ADDR_WIDTH, default 10: DEPTH = 2**ADDR_WIDTH words.
REQ-005 Parameter PAD_WIDTH, default 2: pad field width at word MSBs; used only with VARFIFO_PAD_EN.
REQ-006 Derived values: WR_PER_WORD = WORD_WIDTH/DIN_WIDTH (3), or (WORD_WIDTH-PAD_WIDTH)/DIN_WIDTH with pad enabled (3); RD_PER_WORD = WORD_WIDTH/DOUT_WIDTH (4).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 wr_en  in  1  write request for wr_data.
REQ-010 wr_data  in  DIN_WIDTH  sample to pack.
REQ-011 wr_pad  in  PAD_WIDTH  pad bits for the current word; present only with VARFIFO_PAD_EN.
REQ-012 flush  in  1  commit the partial word.
REQ-013 rd_en  in  1  request the next slice.
REQ-014 rd_data  out  DOUT_WIDTH  unpacked slice, registered.
REQ-015 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-016 full, empty  out  1 each  word_count==DEPTH / word_count==0.
REQ-017 word_count  out  ADDR_WIDTH+1  committed words not yet fully read.
REQ-018 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-019 Sample accepted when wr_en && !full; it SHALL be stored in word bits [wr_ws*DIN_WIDTH +: DIN_WIDTH], after which wr_ws increments.
REQ-020 On acceptance with wr_ws==WR_PER_WORD-1, the assembled word, including that sample, SHALL be written to mem[wr_ptr] on the same edge; wr_ptr and word_count increment, wr_ws returns to 0, staging clears.
REQ-021 Unused bits between WR_PER_WORD*DIN_WIDTH and WORD_WIDTH (and the pad field with pad disabled) SHALL read as 0.
REQ-022 wr_en while full: sample dropped, overflow set, wr_ws unchanged.
REQ-023 flush with wr_ws!=0 SHALL commit the partial word with empty slots 0 and reset wr_ws; flush with wr_ws==0 is a no-op. If wr_en is accepted in the same cycle, that sample is included before commit. A flush commit when full is dropped and sets overflow.
REQ-024 Slice accepted when rd_en && !empty: the next cycle, rd_valid=1 and rd_data = mem[rd_ptr][rd_ws*DOUT_WIDTH +: DOUT_WIDTH]; rd_ws increments.
REQ-025 On accepting slice RD_PER_WORD-1: rd_ptr increments, word_count decrements, rd_ws returns to 0.
REQ-026 rd_en while empty: ignored, rd_valid stays 0, underflow set.
REQ-027 A commit and a final-slice pop on the same edge SHALL leave word_count unchanged.
REQ-028 wr_ptr and rd_ptr are ADDR_WIDTH bits and SHALL wrap DEPTH-1 -> 0.
REQ-029 A word committed on edge N SHALL be readable (empty=0) from the cycle after edge N.

Reset
REQ-030 reset_n low SHALL immediately clear wr_ptr, rd_ptr, wr_ws, rd_ws, staging, word_count, rd_data, rd_valid, overflow and underflow, and force empty=1, full=0, regardless of any operation in progress.
REQ-031 Memory contents are not reset; overflow and underflow clear only on reset.

Configuration
REQ-032 Macro VARFIFO_PAD_EN defined: wr_pad port exists; wr_pad is sampled with the last sample or flush and stored in word bits [WORD_WIDTH-1 -: PAD_WIDTH]; the pad is returned in the top read slice.
REQ-033 Macro VARFIFO_PAD_EN undefined: wr_pad port is absent, and the top bits are 0 per REQ-021.

Verification
REQ-034 Write 0x001, 0x002, 0x003; read x4 -> word 0x00300801, slices 0x01, 0x08, 0x30, 0x00, word_count 1->0.
REQ-035 VARFIFO_PAD_EN, wr_pad=2'b11 with the same samples -> word 0xC0300801, fourth slice 0xC0.
REQ-036 ADDR_WIDTH=4: 48 samples -> full=1, word_count=16; 49th dropped, overflow=1; 4 reads -> word_count=15, full=0.
REQ-037 Write 0x3FF, then flush -> word_count=1, slices 0xFF, 0x03, 0x00, 0x00.
REQ-038 word_count=5, third sample and fourth slice accepted on the same edge -> word_count stays 5.
REQ-039 reset_n low after 2 samples -> empty=1, word_count=0, flags 0; next 3 samples form a word starting at slot 0.
